// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Owns the shared register-file write port in the ID stage and
//             arbitrates it between the in-order WB stage and out-of-band
//             multi-cycle results. Multi-cycle results are buffered in a
//             small FIFO. WB is stalled when the FIFO head has waited too long
//             or the FIFO is full. Buffered results that a younger WB write
//             overwrites (WAW) are squashed.
//  Ports    : clk, rst (async, active-low)
//             wb_valid/wb_gen/wb_fp/wb_rd_addr/wb_rd_data -> WB request
//             wb_stall                                     <- WB not taken
//             mc_valid/mc_is_fp/mc_rd_addr/mc_rd_data      -> MC result
//             mc_ready                                     <- FIFO not full
//             regwrite_gen/regwrite_fp/reg_rd_addr/reg_rd_data <- write port
//             mc_pending, fifo_count                       <- FIFO status
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_valid,
   input  logic                     wb_gen,
   input  logic                     wb_fp,
   input  logic [4:0]               wb_rd_addr,
   input  logic [31:0]              wb_rd_data,
   output logic                     wb_stall,
   input  logic                     mc_valid,
   output logic                     mc_ready,
   input  logic                     mc_is_fp,
   input  logic [4:0]               mc_rd_addr,
   input  logic [31:0]              mc_rd_data,
   output logic                     regwrite_gen,
   output logic                     regwrite_fp,
   output logic [4:0]               reg_rd_addr,
   output logic [31:0]              reg_rd_data,
   output logic                     mc_pending,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int c_AW     = $clog2(DEPTH);
   localparam int c_CW     = c_AW + 1;
   localparam int c_WW     = $clog2(MAX_WAIT + 1);
   localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
   localparam logic [c_WW-1:0] c_MAX_WAIT  = c_WW'(MAX_WAIT);

   // FIFO storage
   logic              r_is_fp [0:DEPTH-1];
   logic [4:0]        r_rd    [0:DEPTH-1];
   logic [31:0]       r_data  [0:DEPTH-1];
   logic [DEPTH-1:0]  r_squash;

   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_CW-1:0]   r_count;
   logic [c_WW-1:0]   r_wait_cnt;

   logic              w_empty;
   logic              w_full;
   logic              w_wb_req;
   logic              w_head_sq;
   logic              w_head_live;
   logic              w_force;
   logic              w_push;
   logic              w_pop;
   logic              w_wb_grant;
   logic              w_mc_grant;
   logic              w_wb_eff;
   logic [DEPTH-1:0]  w_entry_valid;
   logic [DEPTH-1:0]  w_squash_hit;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_DEPTH_CNT);
   // The WB request is masked during reset so the port is silent while rst=0.
   assign w_wb_req    = rst && wb_valid && (wb_gen || wb_fp);
   assign w_head_sq   = !w_empty &&  r_squash[r_rd_ptr];
   assign w_head_live = !w_empty && !r_squash[r_rd_ptr];
   assign w_force     = w_head_live && ((r_wait_cnt >= c_MAX_WAIT) || w_full);
   assign w_push      = mc_valid && !w_full;

   // Port grant: a squashed head drains silently alongside WB; otherwise a
   // forced head beats WB, WB beats a normal head.
   always_comb begin
      w_wb_grant = 1'b0;
      w_mc_grant = 1'b0;
      w_pop      = 1'b0;
      if (w_head_sq) begin
         w_pop      = 1'b1;
         w_wb_grant = w_wb_req;
      end else if (w_force) begin
         w_mc_grant = 1'b1;
         w_pop      = 1'b1;
      end else if (w_wb_req) begin
         w_wb_grant = 1'b1;
      end else if (w_head_live) begin
         w_mc_grant = 1'b1;
         w_pop      = 1'b1;
      end
   end

   assign wb_stall = w_wb_req && !w_wb_grant;

   // Write-port mux; general x0 keeps its grant but never strobes.
   always_comb begin
      regwrite_gen = 1'b0;
      regwrite_fp  = 1'b0;
      reg_rd_addr  = 5'd0;
      reg_rd_data  = 32'd0;
      if (w_wb_grant) begin
         regwrite_gen = wb_gen && (wb_rd_addr != 5'd0);
         regwrite_fp  = wb_fp;
         reg_rd_addr  = wb_rd_addr;
         reg_rd_data  = wb_rd_data;
      end else if (w_mc_grant) begin
         regwrite_gen = !r_is_fp[r_rd_ptr] && (r_rd[r_rd_ptr] != 5'd0);
         regwrite_fp  =  r_is_fp[r_rd_ptr];
         reg_rd_addr  =  r_rd[r_rd_ptr];
         reg_rd_data  =  r_data[r_rd_ptr];
      end
   end

   // A WB write that really lands (x0 excluded) makes older queued results
   // to the same register obsolete.
   assign w_wb_eff = w_wb_grant && (wb_fp || (wb_gen && (wb_rd_addr != 5'd0)));

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [c_AW-1:0] w_offset;
         // Distance from the head, modulo DEPTH; valid when inside the count.
         assign w_offset          = c_AW'(gi) - r_rd_ptr;
         assign w_entry_valid[gi] = ({1'b0, w_offset} < r_count);
         assign w_squash_hit[gi]  = w_wb_eff && w_entry_valid[gi] &&
                                    (r_is_fp[gi] == wb_fp) &&
                                    (r_rd[gi] == wb_rd_addr);
      end
   endgenerate

   // Payload storage needs no reset; validity is carried by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_is_fp[r_wr_ptr] <= mc_is_fp;
         r_rd[r_wr_ptr]    <= mc_rd_addr;
         r_data[r_wr_ptr]  <= mc_rd_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_squash   <= '0;
         r_wait_cnt <= '0;
      end else begin
         // The slot being pushed is never a valid entry (push needs !full),
         // so the squash hits below cannot touch it: a same-cycle push is
         // always treated as younger than the WB write.
         if (w_push) begin
            r_wr_ptr           <= r_wr_ptr + 1'b1;
            r_squash[r_wr_ptr] <= 1'b0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (w_squash_hit[i]) begin
               r_squash[i] <= 1'b1;
            end
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end

         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end

         if (w_pop || !w_head_live) begin
            r_wait_cnt <= '0;
         end else if (r_wait_cnt < c_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

   assign mc_ready   = !w_full;
   assign mc_pending = (r_count != '0);
   assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed self-checking bench for regfile_wb_arbiter
//             (DEPTH=4, MAX_WAIT=8). Inputs change on the falling edge, and
//             outputs are checked 1 time unit later. The write port is
//             mirrored into shadow register files on every rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid, wb_gen, wb_fp;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_data;
   logic        wb_stall;
   logic        mc_valid, mc_ready, mc_is_fp;
   logic [4:0]  mc_rd_addr;
   logic [31:0] mc_rd_data;
   logic        regwrite_gen, regwrite_fp;
   logic [4:0]  reg_rd_addr;
   logic [31:0] reg_rd_data;
   logic        mc_pending;
   logic [2:0]  fifo_count;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_valid     (wb_valid),
      .wb_gen       (wb_gen),
      .wb_fp        (wb_fp),
      .wb_rd_addr   (wb_rd_addr),
      .wb_rd_data   (wb_rd_data),
      .wb_stall     (wb_stall),
      .mc_valid     (mc_valid),
      .mc_ready     (mc_ready),
      .mc_is_fp     (mc_is_fp),
      .mc_rd_addr   (mc_rd_addr),
      .mc_rd_data   (mc_rd_data),
      .regwrite_gen (regwrite_gen),
      .regwrite_fp  (regwrite_fp),
      .reg_rd_addr  (reg_rd_addr),
      .reg_rd_data  (reg_rd_data),
      .mc_pending   (mc_pending),
      .fifo_count   (fifo_count)
   );

   int          n_err = 0;
   int          n_chk = 0;
   int          gen_wr_cnt = 0;
   int          fp_wr_cnt  = 0;
   int          snap;
   logic [31:0] gen_rf [32];
   logic [31:0] fp_rf  [32];

   // Shadow register files fed from the shared write port.
   always @(posedge clk) begin
      if (regwrite_gen) begin
         gen_rf[reg_rd_addr] <= reg_rd_data;
         gen_wr_cnt          <= gen_wr_cnt + 1;
      end
      if (regwrite_fp) begin
         fp_rf[reg_rd_addr] <= reg_rd_data;
         fp_wr_cnt          <= fp_wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic wb_idle();
      wb_valid   = 1'b0;
      wb_gen     = 1'b0;
      wb_fp      = 1'b0;
      wb_rd_addr = 5'd0;
      wb_rd_data = 32'd0;
   endtask

   initial begin
      rst        = 1'b0;
      wb_idle();
      mc_valid   = 1'b0;
      mc_is_fp   = 1'b0;
      mc_rd_addr = 5'd0;
      mc_rd_data = 32'd0;

      // ---- Reset state ----
      repeat (2) @(negedge clk);
      #1;
      chk("rst_regwrite_gen", regwrite_gen, 0);
      chk("rst_regwrite_fp",  regwrite_fp,  0);
      chk("rst_addr",         reg_rd_addr,  0);
      chk("rst_data",         reg_rd_data,  0);
      chk("rst_wb_stall",     wb_stall,     0);
      chk("rst_mc_ready",     mc_ready,     1);
      chk("rst_mc_pending",   mc_pending,   0);
      chk("rst_fifo_count",   fifo_count,   0);
      @(negedge clk);
      rst = 1'b1;

      // ---- T1: single FP result with WB idle ----
      @(negedge clk);
      mc_valid = 1'b1; mc_is_fp = 1'b1; mc_rd_addr = 5'd3; mc_rd_data = 32'h3F80_0000;
      #1;
      chk("t1_ready",          mc_ready,    1);
      chk("t1_no_same_cycle",  regwrite_fp, 0);
      @(negedge clk);
      mc_valid = 1'b0;
      #1;
      chk("t1_count1",  fifo_count,  1);
      chk("t1_pending", mc_pending,  1);
      chk("t1_strobe",  regwrite_fp, 1);
      chk("t1_addr",    reg_rd_addr, 3);
      chk("t1_data",    reg_rd_data, 32'h3F80_0000);
      @(negedge clk);
      #1;
      chk("t1_count0",  fifo_count,  0);
      chk("t1_idle",    regwrite_fp, 0);
      chk("t1_fp3",     fp_rf[3],    32'h3F80_0000);

      // ---- T2: starvation forcing with continuous WB x5 ----
      @(negedge clk);
      wb_valid = 1'b1; wb_gen = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'h55;
      mc_valid = 1'b1; mc_is_fp = 1'b0; mc_rd_addr = 5'd7; mc_rd_data = 32'hAA;
      #1;
      chk("t2_push_stall", wb_stall,    0);
      chk("t2_push_addr",  reg_rd_addr, 5);
      @(negedge clk);
      mc_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("t2_wait_nostall", wb_stall,    0);
         chk("t2_wait_wbaddr",  reg_rd_addr, 5);
         @(negedge clk);
      end
      #1;
      chk("t2_force_stall", wb_stall,     1);
      chk("t2_force_gen",   regwrite_gen, 1);
      chk("t2_force_addr",  reg_rd_addr,  7);
      chk("t2_force_data",  reg_rd_data,  32'hAA);
      @(negedge clk);
      #1;
      chk("t2_after_stall", wb_stall,    0);
      chk("t2_after_addr",  reg_rd_addr, 5);
      chk("t2_after_data",  reg_rd_data, 32'h55);
      chk("t2_after_count", fifo_count,  0);
      chk("t2_x7",          gen_rf[7],   32'hAA);

      // ---- T3: fill the FIFO during continuous WB ----
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mc_valid = 1'b1; mc_is_fp = 1'b0;
         mc_rd_addr = 5'(10 + i); mc_rd_data = 32'h100 + 32'(i);
         #1;
         chk("t3_fill_ready", mc_ready, 1);
         chk("t3_fill_stall", wb_stall, 0);
      end
      @(negedge clk);
      mc_rd_addr = 5'd14; mc_rd_data = 32'h999;   // offered while full: refused
      #1;
      chk("t3_full_ready", mc_ready,    0);
      chk("t3_full_count", fifo_count,  4);
      chk("t3_full_stall", wb_stall,    1);
      chk("t3_full_addr",  reg_rd_addr, 10);
      chk("t3_full_data",  reg_rd_data, 32'h100);
      @(negedge clk);
      mc_valid = 1'b0;
      #1;
      chk("t3_refused_count", fifo_count,  3);
      chk("t3_unstall",       wb_stall,    0);
      chk("t3_ready_again",   mc_ready,    1);
      chk("t3_wb_addr",       reg_rd_addr, 5);
      @(negedge clk);
      wb_idle();
      for (int i = 1; i < 4; i++) begin
         #1;
         chk("t3_drain_gen",  regwrite_gen, 1);
         chk("t3_drain_addr", reg_rd_addr,  5'(10 + i));
         chk("t3_drain_data", reg_rd_data,  32'h100 + 32'(i));
         @(negedge clk);
      end
      #1;
      chk("t3_empty",   fifo_count, 0);
      chk("t3_pending", mc_pending, 0);
      chk("t3_x10",     gen_rf[10], 32'h100);
      chk("t3_x13",     gen_rf[13], 32'h103);

      // ---- T4: WAW squash of a queued x9 ----
      @(negedge clk);
      mc_valid = 1'b1; mc_is_fp = 1'b0; mc_rd_addr = 5'd9; mc_rd_data = 32'h11;
      #1;
      chk("t4_push_nowrite", regwrite_gen, 0);
      @(negedge clk);
      mc_valid = 1'b0;
      wb_valid = 1'b1; wb_gen = 1'b1; wb_rd_addr = 5'd9; wb_rd_data = 32'h22;
      #1;
      chk("t4_wb_gen",   regwrite_gen, 1);
      chk("t4_wb_addr",  reg_rd_addr,  9);
      chk("t4_wb_data",  reg_rd_data,  32'h22);
      chk("t4_wb_count", fifo_count,   1);
      @(negedge clk);
      wb_idle();
      #1;
      chk("t4_sq_gen",     regwrite_gen, 0);
      chk("t4_sq_fp",      regwrite_fp,  0);
      chk("t4_sq_pending", mc_pending,   1);
      @(negedge clk);
      #1;
      chk("t4_pending_drop", mc_pending, 0);
      chk("t4_x9_final",     gen_rf[9],  32'h22);

      // ---- T5: general x0 suppression, FP f0 is real ----
      snap = gen_wr_cnt;
      @(negedge clk);
      mc_valid = 1'b1; mc_is_fp = 1'b0; mc_rd_addr = 5'd0; mc_rd_data = 32'h77;
      #1;
      @(negedge clk);
      mc_is_fp = 1'b1; mc_rd_addr = 5'd0; mc_rd_data = 32'h4040_0000;
      wb_valid = 1'b1; wb_gen = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'h99;
      #1;
      chk("t5_wb_x0_gen",  regwrite_gen, 0);
      chk("t5_wb_x0_stall", wb_stall,    0);
      chk("t5_wb_x0_count", fifo_count,  1);
      @(negedge clk);
      mc_valid = 1'b0;
      wb_idle();
      #1;
      chk("t5_mc_x0_gen",  regwrite_gen, 0);
      chk("t5_mc_x0_fp",   regwrite_fp,  0);
      chk("t5_mc_x0_count", fifo_count,  2);
      @(negedge clk);
      #1;
      chk("t5_f0_fp",   regwrite_fp,  1);
      chk("t5_f0_addr", reg_rd_addr,  0);
      chk("t5_f0_data", reg_rd_data,  32'h4040_0000);
      @(negedge clk);
      #1;
      chk("t5_drained",    fifo_count, 0);
      chk("t5_no_gen_wr",  gen_wr_cnt, snap);
      chk("t5_f0_value",   fp_rf[0],   32'h4040_0000);

      // ---- T6: reset with 3 queued entries while WB is stalled ----
      @(negedge clk);
      wb_valid = 1'b1; wb_gen = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'h55;
      mc_valid = 1'b1; mc_is_fp = 1'b0; mc_rd_addr = 5'd20; mc_rd_data = 32'h1;
      #1;
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         mc_rd_addr = 5'(20 + i); mc_rd_data = 32'(1 + i);
         #1;
      end
      @(negedge clk);
      mc_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("t6_wait_nostall", wb_stall, 0);
         @(negedge clk);
      end
      #1;
      chk("t6_stall",  wb_stall,   1);
      chk("t6_count3", fifo_count, 3);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rst_gen",     regwrite_gen, 0);
      chk("t6_rst_fp",      regwrite_fp,  0);
      chk("t6_rst_addr",    reg_rd_addr,  0);
      chk("t6_rst_data",    reg_rd_data,  0);
      chk("t6_rst_stall",   wb_stall,     0);
      chk("t6_rst_ready",   mc_ready,     1);
      chk("t6_rst_count",   fifo_count,   0);
      chk("t6_rst_pending", mc_pending,   0);
      snap = gen_wr_cnt + fp_wr_cnt;
      @(negedge clk);
      wb_idle();
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      chk("t6_no_writes", gen_wr_cnt + fp_wr_cnt, snap);
      chk("t6_count0",    fifo_count, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
